// File: rtl/avmm_mailbox_target.sv
// AVMM mailbox target: inbound/outbound FIFOs, status/control and doorbell IRQ.
// Define MBOX_WR_RESP_EN to return a wrvalid pulse and status for every write.
module avmm_mailbox_target #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned DW       = 32,
    parameter logic [31:0] ID_VALUE = 32'h4D42_0001
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   avmm_addr,
    input  logic          avmm_read,
    input  logic          avmm_write,
    input  logic [DW-1:0] avmm_wdata,
    input  logic [3:0]    avmm_byteen,
    output logic [DW-1:0] avmm_rdata,
    output logic          avmm_rdvalid,
    output logic          avmm_waitrq,
    output logic          avmm_wrvalid,
    output logic [1:0]    avmm_response,
    output logic [DW-1:0] h2c_data,
    output logic          h2c_empty,
    input  logic          h2c_pop,
    input  logic [DW-1:0] c2h_data,
    input  logic          c2h_push,
    output logic          c2h_full,
    input  logic          doorbell_ack,
    output logic          doorbell_irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [5:0] A_ID   = 6'h00;
    localparam logic [5:0] A_STAT = 6'h01;
    localparam logic [5:0] A_CTRL = 6'h02;
    localparam logic [5:0] A_IN   = 6'h03;
    localparam logic [5:0] A_OUT  = 6'h04;
    localparam logic [5:0] A_DB   = 6'h05;
    localparam logic [5:0] A_OCNT = 6'h06;

    localparam logic [1:0] RESP_OK     = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [DW-1:0] in_mem  [DEPTH];
    logic [DW-1:0] out_mem [DEPTH];

    logic [AW-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d;
    logic [AW-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;

    logic          irq_en_q, irq_en_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          db_q, db_d, irq_q, irq_d;
    logic          rdvalid_q, rdvalid_d, wrvalid_q, wrvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    resp_q, resp_d;

    logic          rd_acc, wr_acc;
    logic [5:0]    waddr;
    logic          in_full, in_empty, out_full, out_empty;
    logic          in_wr, out_rd, in_push, in_pop, out_push, out_pop;
    logic          flush_in, flush_out, clr_stk, db_set;
    logic [1:0]    rd_resp, wr_resp;
    logic [8:0]    in_cnt9, out_cnt9;
    logic [31:0]   status;
    logic          unused_ok;

    assign waddr     = avmm_addr[7:2];
    assign wr_acc    = avmm_write;
    assign rd_acc    = avmm_read & ~avmm_write;
    assign in_full   = (in_cnt_q == CW'(DEPTH));
    assign in_empty  = (in_cnt_q == '0);
    assign out_full  = (out_cnt_q == CW'(DEPTH));
    assign out_empty = (out_cnt_q == '0);
    assign in_cnt9   = 9'(in_cnt_q);
    assign out_cnt9  = 9'(out_cnt_q);
    assign unused_ok = ^{avmm_addr[31:8], avmm_addr[1:0], wr_resp};

    assign status = {15'b0, in_cnt9, 1'b0, db_q, unf_q, ovf_q,
                     out_full, out_empty, in_full, in_empty};

    always_comb begin
        rd_resp   = RESP_OK;
        wr_resp   = RESP_OK;
        rdata_d   = '0;
        irq_en_d  = irq_en_q;
        flush_in  = 1'b0;
        flush_out = 1'b0;
        clr_stk   = 1'b0;
        db_set    = 1'b0;
        in_wr     = 1'b0;
        out_rd    = 1'b0;
        if (wr_acc) begin
            case (waddr)
                A_CTRL: begin
                    if (avmm_byteen[0]) begin
                        irq_en_d  = avmm_wdata[0];
                        flush_in  = avmm_wdata[1];
                        flush_out = avmm_wdata[2];
                        clr_stk   = avmm_wdata[3];
                    end
                end
                A_IN: begin
                    in_wr = (avmm_byteen == 4'hF);
                    if (!in_wr || in_full) wr_resp = RESP_SLVERR;
                end
                A_DB: db_set = |avmm_byteen;
                A_ID, A_STAT, A_OUT, A_OCNT: ;
                default: wr_resp = RESP_DECERR;
            endcase
        end else if (rd_acc) begin
            case (waddr)
                A_ID:   rdata_d = ID_VALUE;
                A_STAT: rdata_d = status;
                A_CTRL: rdata_d = {31'b0, irq_en_q};
                A_OUT: begin
                    out_rd = 1'b1;
                    if (out_empty) rd_resp = RESP_SLVERR;
                    else rdata_d = out_mem[out_rp_q];
                end
                A_OCNT: rdata_d = {23'b0, out_cnt9};
                A_IN, A_DB: ;
                default: rd_resp = RESP_DECERR;
            endcase
        end

        // Full/empty come from pre-edge state, so a push on a full FIFO
        // is refused even when a pop frees a slot in the same cycle.
        in_push  = in_wr & ~in_full;
        in_pop   = h2c_pop & ~in_empty;
        out_push = c2h_push & ~out_full;
        out_pop  = out_rd & ~out_empty;

        ovf_d = (ovf_q & ~clr_stk) | (in_wr & in_full)
              | (c2h_push & out_full);
        unf_d = (unf_q & ~clr_stk) | (out_rd & out_empty)
              | (h2c_pop & in_empty);
        db_d  = db_set | (db_q & ~doorbell_ack);
        irq_d = db_q & irq_en_q;

        rdvalid_d = rd_acc;
`ifdef MBOX_WR_RESP_EN
        wrvalid_d = wr_acc;
        resp_d    = wr_acc ? wr_resp : rd_resp;
`else
        wrvalid_d = 1'b0;
        resp_d    = rd_resp;
`endif
    end

    always_comb begin
        in_wp_d   = in_wp_q + AW'(in_push);
        in_rp_d   = in_rp_q + AW'(in_pop);
        out_wp_d  = out_wp_q + AW'(out_push);
        out_rp_d  = out_rp_q + AW'(out_pop);
        in_cnt_d  = in_cnt_q + CW'(in_push) - CW'(in_pop);
        out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
        if (flush_in) begin
            in_wp_d  = '0;
            in_rp_d  = '0;
            in_cnt_d = '0;
        end
        if (flush_out) begin
            out_wp_d  = '0;
            out_rp_d  = '0;
            out_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wp_q] <= avmm_wdata;
        if (out_push) out_mem[out_wp_q] <= c2h_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_wp_q   <= '0;
            in_rp_q   <= '0;
            in_cnt_q  <= '0;
            out_wp_q  <= '0;
            out_rp_q  <= '0;
            out_cnt_q <= '0;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            db_q      <= 1'b0;
            irq_q     <= 1'b0;
            rdvalid_q <= 1'b0;
            wrvalid_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OK;
        end else begin
            in_wp_q   <= in_wp_d;
            in_rp_q   <= in_rp_d;
            in_cnt_q  <= in_cnt_d;
            out_wp_q  <= out_wp_d;
            out_rp_q  <= out_rp_d;
            out_cnt_q <= out_cnt_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            db_q      <= db_d;
            irq_q     <= irq_d;
            rdvalid_q <= rdvalid_d;
            wrvalid_q <= wrvalid_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    // Responses are masked while reset is held so a pending one is cancelled.
    assign avmm_rdvalid  = rdvalid_q & rst_n;
    assign avmm_wrvalid  = wrvalid_q & rst_n;
    assign avmm_rdata    = rdata_q;
    assign avmm_response = resp_q;
    assign avmm_waitrq   = ~rst_n;
    assign h2c_empty     = in_empty;
    assign h2c_data      = in_empty ? '0 : in_mem[in_rp_q];
    assign c2h_full      = out_full;
    assign doorbell_irq  = irq_q;

endmodule

// File: tb/tb_avmm_mailbox_target.sv
// Bench for avmm_mailbox_target: queue-based mailbox model checked every cycle
// plus directed scenarios with literal expectations.
module tb_avmm_mailbox_target;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] avmm_addr;
    logic        avmm_read;
    logic        avmm_write;
    logic [31:0] avmm_wdata;
    logic [3:0]  avmm_byteen;
    logic [31:0] avmm_rdata;
    logic        avmm_rdvalid;
    logic        avmm_waitrq;
    logic        avmm_wrvalid;
    logic [1:0]  avmm_response;
    logic [31:0] h2c_data;
    logic        h2c_empty;
    logic        h2c_pop;
    logic [31:0] c2h_data;
    logic        c2h_push;
    logic        c2h_full;
    logic        doorbell_ack;
    logic        doorbell_irq;

    always #5 clk = ~clk;

    avmm_mailbox_target #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .avmm_addr    (avmm_addr),
        .avmm_read    (avmm_read),
        .avmm_write   (avmm_write),
        .avmm_wdata   (avmm_wdata),
        .avmm_byteen  (avmm_byteen),
        .avmm_rdata   (avmm_rdata),
        .avmm_rdvalid (avmm_rdvalid),
        .avmm_waitrq  (avmm_waitrq),
        .avmm_wrvalid (avmm_wrvalid),
        .avmm_response(avmm_response),
        .h2c_data     (h2c_data),
        .h2c_empty    (h2c_empty),
        .h2c_pop      (h2c_pop),
        .c2h_data     (c2h_data),
        .c2h_push     (c2h_push),
        .c2h_full     (c2h_full),
        .doorbell_ack (doorbell_ack),
        .doorbell_irq (doorbell_irq)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    logic [31:0] inq[$];
    logic [31:0] outq[$];
    bit          m_ovf, m_unf, m_db, m_irqen, m_irq;
    bit          m_rdv, m_wrv;
    logic [31:0] m_rdata;
    logic [1:0]  m_resp;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Mailbox model: applies one clock edge worth of the register-map rules.
    task automatic model_step();
        bit ifull, iemp, ofull, oemp, rd;
        bit new_ovf, new_unf, clr, fin, fout, dbset, nirq;
        logic [1:0] wresp, rresp;
        logic [31:0] st;
        int w;
        if (!rst_n) begin
            inq.delete();
            outq.delete();
            m_ovf = 0; m_unf = 0; m_db = 0; m_irqen = 0; m_irq = 0;
            m_rdv = 0; m_wrv = 0; m_rdata = 0; m_resp = 0;
            return;
        end
        ifull = (inq.size() == DEPTH);
        iemp  = (inq.size() == 0);
        ofull = (outq.size() == DEPTH);
        oemp  = (outq.size() == 0);
        rd    = avmm_read && !avmm_write;
        w     = int'(avmm_addr[7:2]);
        new_ovf = 0; new_unf = 0; clr = 0; fin = 0; fout = 0; dbset = 0;
        wresp = 2'b00; rresp = 2'b00;
        nirq = m_db && m_irqen;
        st = 32'(iemp) | (32'(ifull) << 1) | (32'(oemp) << 2)
           | (32'(ofull) << 3) | (32'(m_ovf) << 4) | (32'(m_unf) << 5)
           | (32'(m_db) << 6) | (32'(inq.size()) << 8);
        m_rdata = 0;
        if (h2c_pop) begin
            if (iemp) new_unf = 1;
            else void'(inq.pop_front());
        end
        if (c2h_push) begin
            if (ofull) new_ovf = 1;
            else outq.push_back(c2h_data);
        end
        if (avmm_write) begin
            case (w)
                2: if (avmm_byteen[0]) begin
                    m_irqen = avmm_wdata[0];
                    fin  = avmm_wdata[1];
                    fout = avmm_wdata[2];
                    clr  = avmm_wdata[3];
                end
                3: if (avmm_byteen != 4'hF) wresp = 2'b10;
                   else if (ifull) begin wresp = 2'b10; new_ovf = 1; end
                   else inq.push_back(avmm_wdata);
                5: if (avmm_byteen != 0) dbset = 1;
                0, 1, 4, 6: ;
                default: wresp = 2'b11;
            endcase
        end else if (rd) begin
            case (w)
                0: m_rdata = 32'h4D42_0001;
                1: m_rdata = st;
                2: m_rdata = 32'(m_irqen);
                4: if (oemp) begin rresp = 2'b10; new_unf = 1; end
                   else m_rdata = outq.pop_front();
                6: m_rdata = 32'(outq.size() - (rd && !oemp && w == 4));
                3, 5: ;
                default: rresp = 2'b11;
            endcase
        end
        if (fin) inq.delete();
        if (fout) outq.delete();
        m_ovf = (m_ovf && !clr) || new_ovf;
        m_unf = (m_unf && !clr) || new_unf;
        m_db  = dbset ? 1'b1 : (doorbell_ack ? 1'b0 : m_db);
        m_irq = nirq;
        m_rdv = rd;
`ifdef MBOX_WR_RESP_EN
        m_wrv = avmm_write;
`else
        m_wrv = 0;
`endif
        m_resp = m_wrv ? wresp : rresp;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("waitrq", 32'(avmm_waitrq), 32'(!rst_n));
            chk("rdvalid", 32'(avmm_rdvalid), 32'(m_rdv && rst_n));
            chk("wrvalid", 32'(avmm_wrvalid), 32'(m_wrv && rst_n));
            if (m_rdv && rst_n) begin
                chk("rdata", avmm_rdata, m_rdata);
                chk("rd_resp", 32'(avmm_response), 32'(m_resp));
            end
            if (m_wrv && rst_n)
                chk("wr_resp", 32'(avmm_response), 32'(m_resp));
            chk("h2c_empty", 32'(h2c_empty), 32'(inq.size() == 0));
            chk("h2c_data", h2c_data, (inq.size() != 0) ? inq[0] : 32'h0);
            chk("c2h_full", 32'(c2h_full), 32'(outq.size() == DEPTH));
            chk("irq", 32'(doorbell_irq), 32'(m_irq));
        end
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [1:0] r);
        avmm_addr = {24'h0, a};
        avmm_wdata = d;
        avmm_byteen = be;
        avmm_write = 1;
        tick();
        r = avmm_response;
        avmm_write = 0;
        avmm_byteen = 4'hF;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d,
                      output logic [1:0] r);
        avmm_addr = {24'h0, a};
        avmm_read = 1;
        tick();
        d = avmm_rdata;
        r = avmm_response;
        avmm_read = 0;
    endtask

    task automatic cpush(input logic [31:0] d);
        c2h_data = d;
        c2h_push = 1;
        tick();
        c2h_push = 0;
    endtask

    task automatic hpop();
        h2c_pop = 1;
        tick();
        h2c_pop = 0;
    endtask

    logic [31:0] d;
    logic [1:0]  r;

    initial begin
        rst_n = 0;
        avmm_addr = 0; avmm_read = 0; avmm_write = 0;
        avmm_wdata = 0; avmm_byteen = 4'hF;
        h2c_pop = 0; c2h_data = 0; c2h_push = 0; doorbell_ack = 0;
        tick();
        tick();
        chk_en = 1;
        chk("rst_waitrq", 32'(avmm_waitrq), 32'd1);
        chk("rst_h2c_empty", 32'(h2c_empty), 32'd1);
        chk("rst_rdvalid", 32'(avmm_rdvalid), 32'd0);
        rst_n = 1;
        tick();

        rd(8'h00, d, r);
        chk("id_data", d, 32'h4D42_0001);
        chk("id_resp", 32'(r), 32'd0);
        rd(8'h04, d, r);
        chk("status_reset", d, 32'h0000_0005);

        for (int i = 0; i < 16; i++) wr(8'h0C, 32'h100 + i, 4'hF, r);
        wr(8'h0C, 32'h1FF, 4'hF, r);
`ifdef MBOX_WR_RESP_EN
        chk("in_ovf_resp", 32'(r), 32'd2);
`endif
        rd(8'h04, d, r);
        chk("status_in_full", d, 32'h0000_1016);
        for (int i = 0; i < 16; i++) begin
            chk("h2c_word", h2c_data, 32'h100 + i);
            hpop();
        end
        chk("h2c_drained", 32'(h2c_empty), 32'd1);

        for (int i = 0; i < 3; i++) cpush(32'hA0 + i);
        for (int i = 0; i < 4; i++) begin
            rd(8'h10, d, r);
            chk("out_word", d, (i < 3) ? 32'hA0 + i : 32'h0);
            chk("out_resp", 32'(r), (i < 3) ? 32'd0 : 32'd2);
        end
        rd(8'h04, d, r);
        chk("status_sticky", d, 32'h0000_0035);
        wr(8'h08, 32'h8, 4'hF, r);
        rd(8'h04, d, r);
        chk("status_cleared", d, 32'h0000_0005);

        wr(8'h08, 32'h1, 4'hF, r);
        wr(8'h14, 32'h1, 4'hF, r);
        tick();
        chk("irq_set", 32'(doorbell_irq), 32'd1);
        doorbell_ack = 1;
        wr(8'h14, 32'h1, 4'hF, r);
        doorbell_ack = 0;
        tick();
        chk("irq_set_wins", 32'(doorbell_irq), 32'd1);
        doorbell_ack = 1;
        tick();
        doorbell_ack = 0;
        tick();
        chk("irq_acked", 32'(doorbell_irq), 32'd0);
        wr(8'h08, 32'h0, 4'hE, r);
        rd(8'h08, d, r);
        chk("ctrl_byteen", d, 32'h1);

        for (int i = 0; i < 5; i++) wr(8'h0C, 32'h200 + i, 4'hF, r);
        h2c_pop = 1;
        wr(8'h08, 32'h2, 4'hF, r);
        h2c_pop = 0;
        chk("flush_in_empty", 32'(h2c_empty), 32'd1);
        rd(8'h04, d, r);
        chk("status_flushed", d, 32'h0000_0005);
        rd(8'h40, d, r);
        chk("decerr_data", d, 32'h0);
        chk("decerr_resp", 32'(r), 32'd3);
        wr(8'h40, 32'hFFFF_FFFF, 4'hF, r);
        wr(8'h0C, 32'h333, 4'h7, r);

        wr(8'h0C, 32'h300, 4'hF, r);
        wr(8'h0C, 32'h301, 4'hF, r);
        h2c_pop = 1;
        wr(8'h0C, 32'h302, 4'hF, r);
        h2c_pop = 0;
        rd(8'h04, d, r);
        chk("status_pushpop", d, 32'h0000_0204);
        for (int i = 0; i < 16; i++) cpush(32'hC0 + i);
        c2h_data = 32'hDEAD;
        c2h_push = 1;
        rd(8'h10, d, r);
        c2h_push = 0;
        chk("out_full_pop", d, 32'hC0);
        rd(8'h18, d, r);
        chk("out_cnt", d, 32'd15);
        rd(8'h04, d, r);
        chk("status_out_ovf", d, 32'h0000_0210);
        hpop();
        hpop();
        c2h_push = 1;
        wr(8'h08, 32'h4, 4'hF, r);
        c2h_push = 0;
        rd(8'h18, d, r);
        chk("flush_out_cnt", d, 32'd0);
        h2c_pop = 1;
        wr(8'h08, 32'h8, 4'hF, r);
        h2c_pop = 0;
        rd(8'h04, d, r);
        chk("clr_vs_err", d, 32'h0000_0025);

        wr(8'h0C, 32'h400, 4'hF, r);
        avmm_addr = 32'h0;
        avmm_read = 1;
        tick();
        avmm_read = 0;
        rst_n = 0;
        #1;
        chk("rst_cancel_rdv", 32'(avmm_rdvalid), 32'd0);
        chk("rst_cancel_wait", 32'(avmm_waitrq), 32'd1);
        tick();
        tick();
        rst_n = 1;
        tick();
        chk("rst_fifo_lost", 32'(h2c_empty), 32'd1);
        wr(8'h14, 32'h1, 4'h1, r);
        wr(8'h08, 32'h1, 4'hF, r);
        tick();
        tick();

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
